// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential reads into a DEPTH-entry queue, with redirect and permanent halt.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_unit #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_rd,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   data_mem_q [DEPTH];
    logic [WIDTH-1:0]   data_mem_d [DEPTH];
    logic [WIDTH-1:0]   pc_mem_q [DEPTH];
    logic [WIDTH-1:0]   pc_mem_d [DEPTH];

    logic               running_s, redirect_s, halt_s, credit_s, issue_s;
    logic               head_valid_s, resp_s, bypass_s, push_s, pop_s;
    logic [CNT_W:0]     occupancy_s;

    // Control decode: credit, issue, squash, bypass and queue handshakes.
    always_comb begin
        running_s    = (state_q == RUN);
        redirect_s   = running_s && redirect;
        halt_s       = running_s && halt;
        occupancy_s  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        credit_s     = (occupancy_s < DEPTH_C);
        // Reset gating keeps the strobe low while the async reset is held.
        issue_s      = running_s && !redirect && !halt && credit_s && !reset;
        head_valid_s = (count_q != {CNT_W{1'b0}});
        resp_s       = inflight_q && !redirect_s;
`ifdef FETCH_BYPASS_EN
        bypass_s     = resp_s && !head_valid_s;
`else
        bypass_s     = 1'b0;
`endif
        pop_s        = head_valid_s && inst_ready;
        push_s       = resp_s && !(bypass_s && inst_ready);
    end

    // Memory read port.
    always_comb begin
        imem_rd   = issue_s;
        imem_addr = {WIDTH{1'b0}};
        if (issue_s) begin
            imem_addr = fetch_pc_q;
        end else begin
            imem_addr = {WIDTH{1'b0}};
        end
    end

    // Decode-side outputs: queue head first, then the bypassed response, else zero.
    always_comb begin
        inst_valid = head_valid_s || bypass_s;
        inst       = {WIDTH{1'b0}};
        inst_pc    = {WIDTH{1'b0}};
        if (head_valid_s) begin
            inst    = data_mem_q[rd_ptr_q];
            inst_pc = pc_mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            inst    = imem_data;
            inst_pc = inflight_pc_q;
        end else begin
            inst    = {WIDTH{1'b0}};
            inst_pc = {WIDTH{1'b0}};
        end
    end

    // Next-state for state, fetch PC and the in-flight tracker.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue_s;
        inflight_pc_d = inflight_pc_q;
        if (halt_s) begin
            state_d = HALTED;
        end else begin
            state_d = state_q;
        end
        if (redirect_s) begin
            fetch_pc_d = redirect_pc;
        end else if (issue_s) begin
            fetch_pc_d    = fetch_pc_q + WIDTH'(1);
            inflight_pc_d = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Next-state for queue pointers, occupancy and storage; redirect flushes everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_mem_d = data_mem_q;
        pc_mem_d   = pc_mem_q;
        if (redirect_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_d[wr_ptr_q] = imem_data;
                pc_mem_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= {WIDTH{1'b0}};
            inflight_q    <= 1'b0;
            inflight_pc_q <= {WIDTH{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        data_mem_q <= data_mem_d;
        pc_mem_q   <= pc_mem_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue of outstanding fetch addresses predicts every output each cycle.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             imem_rd;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_data = 16'h0000;
    logic             redirect = 1'b0;
    logic [WIDTH-1:0] redirect_pc = 16'h0000;
    logic             halt = 1'b0;
    logic             inst_valid;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] inst_pc;
    logic             inst_ready = 1'b0;

    fetch_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    bit          running = 1'b1;
    logic [15:0] next_read = 16'h0000;
    bit          rd_last = 1'b0;
    logic [15:0] addr_last = 16'h0000;
    int          assert_cnt = 0;
    int          fail_cnt = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1A00 + a * 16'h1101;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance the model, return at next posedge+1.
    task automatic cycle(input bit rdy, input bit redir, input logic [15:0] rpc, input bit hlt);
        bit exp_rd;
        bit exp_valid;
        bit acc_redir;
        imem_data   = rd_last ? mem_word(addr_last) : 16'($urandom);
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        halt        = hlt;
        @(negedge clk);
        acc_redir = running && redir;
        exp_rd    = running && !redir && !hlt && (pend.size() < DEPTH);
        exp_valid = 1'b0;
        if (pend.size() > 0) begin
            if (pend[0].cyc + LAT <= cyc) exp_valid = 1'b1;
            if (LAT == 1 && acc_redir && pend[0].cyc + 1 == cyc) exp_valid = 1'b0;
        end
        check_eq("imem_rd", imem_rd, exp_rd);
        if (exp_rd) check_eq("imem_addr", imem_addr, next_read);
        check_eq("inst_valid", inst_valid, exp_valid);
        check_eq("inst", inst, exp_valid ? mem_word(pend[0].addr) : 16'h0000);
        check_eq("inst_pc", inst_pc, exp_valid ? pend[0].addr : 16'h0000);
        if (exp_valid && rdy) void'(pend.pop_front());
        if (acc_redir) begin
            pend.delete();
            next_read = rpc;
            if (hlt) running = 1'b0;
        end else if (running && hlt) begin
            running = 1'b0;
        end
        rd_last   = exp_rd;
        addr_last = next_read;
        if (exp_rd) begin
            pend.push_back('{next_read, cyc});
            next_read = next_read + 16'h0001;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: raise reset between edges, check outputs drop at once, release a cycle later.
    task automatic do_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_imem_rd", imem_rd, 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'd0);
        check_eq("rst_inst_valid", inst_valid, 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        pend.delete();
        running   = 1'b1;
        next_read = 16'h0000;
        rd_last   = 1'b0;
    endtask

    task automatic random_cycle(input int redir_pct, input int halt_pct);
        bit          rdy;
        bit          rd;
        bit          hl;
        logic [15:0] rpc;
        rdy = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 99) < redir_pct);
        hl  = ($urandom_range(0, 99) < halt_pct);
        rpc = ($urandom_range(0, 1) != 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
        cycle(rdy, rd, rpc, hl);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset_mid();
        repeat (8) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b1, 16'h0040, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b1, 16'hFFFE, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int r = 0; r < 4; r++) begin
            repeat (150) random_cycle(5, 0);
            repeat (2) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
            if (r % 2 == 1) cycle(1'b0, 1'b1, 16'h0100, 1'b1);
            else cycle(1'b1, 1'b0, 16'h0000, 1'b1);
            repeat (30) random_cycle(20, 20);
            do_reset_mid();
        end
        repeat (20) random_cycle(5, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 Parameter WIDTH, default 16: instruction word and PC width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 imem_rd  output  1  instruction memory read strobe.
REQ-006 imem_addr  output  WIDTH  read address; meaningful only while imem_rd=1.
REQ-007 imem_data  input  WIDTH  read data, valid exactly one cycle after imem_rd=1.
REQ-008 redirect  input  1  one-cycle pulse: discard fetched/in-flight words, restart at redirect_pc.
REQ-009 redirect_pc  input  WIDTH  new fetch address, sampled when redirect=1.
REQ-010 halt  input  1  one-cycle pulse: stop fetching permanently until reset.
REQ-011 inst_valid  output  1  inst/inst_pc hold a valid instruction for decode.
REQ-012 inst  output  WIDTH  instruction word at queue head.
REQ-013 inst_pc  output  WIDTH  address inst was fetched from.
REQ-014 inst_ready  input  1  decode accepts; transfer when inst_valid and inst_ready both 1.

Function
REQ-015 States: RUN (issue reads), HALTED (no reads); no other states.
REQ-016 fetch_pc register: address of next read; increments by 1 per issued read, 0xFFFF wraps to 0x0000.
REQ-017 RUN: imem_rd=1, imem_addr=fetch_pc whenever occupancy + in-flight (0 or 1) < DEPTH and no redirect/halt this cycle.
REQ-018 Response cycle after a read: {imem_data, issued address} pushed to queue tail unless squashed.
REQ-019 Queue is FIFO; head drives inst/inst_pc; pop on transfer; simultaneous push and pop keeps occupancy unchanged.
REQ-020 Credit rule in REQ-017 guarantees no push when full; push-on-full is unreachable and never overwrites.
REQ-021 inst_valid=1 iff queue non-empty (plus bypass case, REQ-033); inst=0, inst_pc=0 when inst_valid=0.
REQ-022 Without bypass: read at cycle N -> inst_valid earliest at N+2; sustained throughput 1 instruction/cycle with inst_ready=1.
REQ-023 redirect: same cycle no read issued; next edge empties queue, fetch_pc<=redirect_pc, squashes any response due next cycle; first new read next cycle.
REQ-024 Transfer in redirect cycle still completes (decode has consumed it); remaining entries are discarded.
REQ-025 halt in RUN: no read that cycle; next edge state<=HALTED; in-flight response still pushed; queue keeps draining normally.
REQ-026 halt and redirect same cycle: queue flushed and in-flight squashed per REQ-023, state<=HALTED, fetch_pc<=redirect_pc.
REQ-027 HALTED: imem_rd=0; redirect ignored; halt ignored; exit only via reset.

Reset
REQ-028 reset=1 immediately forces imem_rd=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0.
REQ-029 Reset clears queue pointers/occupancy, in-flight and squash flags, fetch_pc=0, state=RUN.
REQ-030 Reset mid-read: pending response discarded; first read after release at address 0 in first clk edge with reset=0.
REQ-031 Queue storage contents need no reset.

Configuration
REQ-032 Macro FETCH_BYPASS_EN selects the empty-queue bypass path.
REQ-033 Defined: queue empty and unsquashed response arriving -> inst_valid=1 same cycle, inst=imem_data, inst_pc=issued address; if inst_ready=1 word is not enqueued; read-to-valid latency 1 cycle.
REQ-034 Not defined: every response enqueued first; latency per REQ-022; no combinational path imem_data -> inst.

Verification
REQ-035 Reset release, imem[0..3]=0x1A00,0x2B01,0x3C02,0x4D03, inst_ready=1 -> transfers in order with inst_pc 0,1,2,3, one per cycle after initial latency.
REQ-036 inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 reads (addr 0..3), then imem_rd=0 with inst_valid=1 held, inst=imem[0].
REQ-037 Queue holds addr 4..6, read of 7 in flight, redirect with redirect_pc=0x0040 -> addr 7 data never appears; next transfer inst_pc=0x0040.
REQ-038 redirect_pc=0xFFFE, inst_ready=1 -> transfers inst_pc 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-039 halt while 2 entries queued and 1 in flight -> exactly 3 further transfers, imem_rd stays 0; later redirect has no effect.
REQ-040 reset asserted mid-stream between edges -> inst_valid and imem_rd fall 0 without clk edge; after release first imem_addr=0x0000.
